// File: rtl/tag_sched.sv
// Four-ingress tag scheduler: round-robin grant into a single output register,
// gated by per-output credit counters that track packets not yet transmitted.

module tag_sched_cnt #(
  parameter int CREDITS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       underflow
);

  // A done with nothing outstanding is reported and otherwise ignored.
  assign underflow = dec && (cnt == 4'd0) && !reset;

  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (inc && !dec)
      cnt <= cnt + 4'd1;
    else if (dec && !inc && cnt != 4'd0)
      cnt <= cnt - 4'd1;
  end

endmodule

module tag_sched #(
  parameter int CREDITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0][11:0] req_data,
  input  logic [3:0]       req_valid,
  output logic [3:0]       req_ready,
  output logic [13:0]      tag_data,
  output logic             tag_valid,
  input  logic             tag_ready,
  input  logic [3:0]       done_eop,
  output logic [3:0][3:0]  outstanding,
  output logic             err_underflow
);

  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [1:0] oif;
    logic [9:0] tag;
  } req_t;

  req_t [NUM_LANES-1:0] req;
  logic [NUM_LANES-1:0] elig;
  logic [NUM_LANES-1:0] inc;
  logic [NUM_LANES-1:0] uf;
  logic [1:0]           rr_ptr;
  logic [1:0]           gnt_idx;
  logic                 gnt_vld;
  logic                 load;
  logic                 grant;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      assign req[i]  = req_t'(req_data[i]);
      assign elig[i] = req_valid[i] && (outstanding[req[i].oif] < 4'(CREDITS));
      assign inc[i]  = grant && (req[gnt_idx].oif == 2'(i));

      tag_sched_cnt #(.CREDITS(CREDITS)) u_cnt (
        .clock     (clock),
        .reset     (reset),
        .inc       (inc[i]),
        .dec       (done_eop[i]),
        .cnt       (outstanding[i]),
        .underflow (uf[i])
      );
    end
  endgenerate

  // Walk from the far end back toward rr_ptr so the nearest eligible wins.
  always_comb begin
    logic [1:0] idx;
    idx     = rr_ptr;
    gnt_vld = 1'b0;
    gnt_idx = rr_ptr;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign load      = !tag_valid || tag_ready;
  assign grant     = load && gnt_vld && !reset;
  assign req_ready = grant ? (4'b0001 << gnt_idx) : 4'b0000;

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid <= 1'b0;
      tag_data  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (load)
        tag_valid <= gnt_vld;
      if (grant) begin
        tag_data <= {req[gnt_idx].oif, gnt_idx, req[gnt_idx].tag};
        rr_ptr   <= gnt_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      err_underflow <= 1'b0;
    else if (|uf)
      err_underflow <= 1'b1;
  end

endmodule

// File: tb/tb_tag_sched.sv
// Randomized scoreboard bench for tag_sched with a cycle-level reference model.

module tb_tag_sched;

  localparam int CREDITS = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [3:0][11:0] req_data;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [13:0]      tag_data;
  logic             tag_valid;
  logic             tag_ready;
  logic [3:0]       done_eop;
  logic [3:0][3:0]  outstanding;
  logic             err_underflow;

  int errors = 0;
  int checks = 0;

  int  m_cnt [4];
  int  m_rr;
  bit  m_full;
  bit  m_err;
  int  n_grant = 0;
  logic [13:0] exp_q [$];

  tag_sched #(.CREDITS(CREDITS)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .tag_data      (tag_data),
    .tag_valid     (tag_valid),
    .tag_ready     (tag_ready),
    .done_eop      (done_eop),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: evaluated at the falling edge on the inputs that will be
  // sampled at the next rising edge, then advanced to that edge's outcome.
  always @(negedge clock) begin
    int g;
    bit ld;
    logic [3:0] exp_rdy;
    ld = !m_full || tag_ready;
    g  = -1;
    if (!reset && ld)
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_rr + k) % 4;
        if (g < 0 && req_valid[idx] && m_cnt[req_data[idx][11:10]] < CREDITS)
          g = idx;
      end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("req_ready", int'(req_ready), int'(exp_rdy));
    chk("tag_valid", int'(tag_valid), int'(m_full));
    chk("err_underflow", int'(err_underflow), int'(m_err));
    for (int o = 0; o < 4; o++)
      chk($sformatf("outstanding[%0d]", o), int'(outstanding[o]), m_cnt[o]);

    if (reset) begin
      for (int o = 0; o < 4; o++) m_cnt[o] = 0;
      m_rr = 0; m_full = 0; m_err = 0;
      exp_q.delete();
    end else begin
      for (int o = 0; o < 4; o++) begin
        bit up, dn;
        up = (g >= 0) && (int'(req_data[g][11:10]) == o);
        dn = done_eop[o];
        if (dn && m_cnt[o] == 0) m_err = 1;
        if (up && !dn) m_cnt[o]++;
        else if (dn && !up && m_cnt[o] > 0) m_cnt[o]--;
      end
      if (ld) m_full = (g >= 0);
      if (g >= 0) begin
        exp_q.push_back({req_data[g][11:10], 2'(g), req_data[g][9:0]});
        m_rr = (g + 1) % 4;
        n_grant++;
      end
    end
  end

  // Monitor: the presented tag must match the oldest expected one while held.
  always @(negedge clock) begin
    if (!reset && tag_valid) begin
      if (exp_q.size() == 0)
        chk("tag_unexpected", 1, 0);
      else begin
        chk("tag_data", int'(tag_data), int'(exp_q[0]));
        if (tag_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic idle();
    req_valid = '0; req_data = '0; done_eop = '0; tag_ready = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int g0;
    for (int o = 0; o < 4; o++) m_cnt[o] = 0;
    m_rr = 0; m_full = 0; m_err = 0;
    idle();
    reset = 1'b1;
    step(3);
    reset = 1'b0;

    // All four requesters, distinct outputs, downstream always ready.
    for (int i = 0; i < 4; i++) req_data[i] = {2'(i), 10'(100 + i)};
    req_valid = 4'hf;
    step(5);
    idle();
    step(2);
    reset = 1'b1; step(1); reset = 1'b0;

    // Requester 0 streams to output 2 until credits run out.
    req_valid = 4'b0001;
    req_data[0] = {2'd2, 10'h155};
    step(12);
    @(negedge clock);
    chk("credit_full_cnt", int'(outstanding[2]), CREDITS);
    chk("credit_full_rdy", int'(req_ready[0]), 0);
    step(1);
    g0 = n_grant;
    done_eop = 4'b0100;
    step(1);
    done_eop = 4'b0000;
    step(6);
    chk("credit_one_more", n_grant - g0, 1);
    idle();

    // Downstream stalls with a valid entry held; tag must not move.
    reset = 1'b1; step(1); reset = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i] = {2'(3 - i), 10'(i * 7)};
    req_valid = 4'hf;
    step(1);
    tag_ready = 1'b0;
    step(5);
    tag_ready = 1'b1;
    step(3);
    idle();

    // Underflow on an empty output.
    reset = 1'b1; step(1); reset = 1'b0;
    done_eop = 4'b1000;
    step(1);
    done_eop = 4'b0000;
    step(2);
    @(negedge clock);
    chk("underflow_flag", int'(err_underflow), 1);
    chk("underflow_cnt", int'(outstanding[3]), 0);
    step(1);

    // Random traffic, including occasional mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) req_data[i] = 12'($urandom);
      tag_ready = ($urandom_range(0, 9) < 7);
      for (int o = 0; o < 4; o++) done_eop[o] = ($urandom_range(0, 3) == 0);
      step(1);
    end
    idle();
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
